// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file debug path.
// Holds the register-file geometry and the scan reader FSM state type.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_COUNT  = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    DONE
  } scan_state_t;

endpackage

// File: rtl/regfile_scan_reader.sv
// Sequential debug reader for the CPU register file.
// On a start pulse, walks indices FIRST_REG..LAST_REG through one regfile read port.
// Each word is streamed out with its index over a valid/ready handshake.
//
// Ports:
//   clk, rst         clock (rising edge) and asynchronous active-low reset
//   start            scan request, sampled only while idle
//   abort            synchronous abort back to idle, highest priority
//   rf_raddr         regfile read address (driven only in READ, 0 otherwise)
//   rf_rdata         combinational regfile read data
//   dout_valid/ready output handshake
//   dout_data/addr   captured word and its index
//   dout_last        marks the word at LAST_REG
//   busy             high in every state except IDLE
//   done             one-cycle pulse after the final handshake
//   checksum         XOR of all handshaken words (only with SCAN_CHECKSUM_EN)
//
// Optional feature: define SCAN_CHECKSUM_EN to add the checksum output.
module regfile_scan_reader
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W    = REG_ADDR_W,
  parameter int unsigned DATA_W    = REG_DATA_W,
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = REG_COUNT - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic [ADDR_W-1:0] dout_addr,
  output logic              dout_last,
  output logic              busy,
  output logic              done
`ifdef SCAN_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [ADDR_W-1:0] FirstIdx = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(LAST_REG);

  scan_state_t       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;
  logic              hs;

  assign hs = valid_q && dout_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    addr_d  = addr_q;
    last_d  = last_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          idx_d   = FirstIdx;
        end
      end
      READ: begin
        data_d  = rf_rdata;
        addr_d  = idx_q;
        last_d  = (idx_q == LastIdx);
        valid_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (hs) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = DONE;
          end else begin
            // last_q guards the increment, so idx never wraps past LAST_REG
            idx_d   = idx_q + ADDR_W'(1);
            state_d = READ;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides handshake and any other transition
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= FirstIdx;
      data_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  // The read port belongs to this block only while a word is being fetched
  assign rf_raddr   = (state_q == READ) ? idx_q : '0;
  assign dout_valid = valid_q;
  assign dout_data  = data_q;
  assign dout_addr  = addr_q;
  assign dout_last  = last_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

`ifdef SCAN_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if ((state_q == IDLE) && start) begin
      csum_d = '0;
    end else if ((state_q == WAIT) && hs && !abort) begin
      csum_d = csum_q ^ data_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Self-checking bench for regfile_scan_reader: table of scan scenarios driven against a
// scoreboard, plus hand-written reset, single-word and checksum sequences.
module tb_regfile_scan_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, abort = 1'b0, dout_ready = 1'b1;
  logic [4:0]  rf_raddr, dout_addr;
  logic [31:0] rf_rdata, dout_data;
  logic        dout_valid, dout_last, busy, done;

  logic        start1 = 1'b0, abort1 = 1'b0, dout_ready1 = 1'b1;
  logic [4:0]  rf_raddr1, dout_addr1;
  logic [31:0] rf_rdata1, dout_data1;
  logic        dout_valid1, dout_last1, busy1, done1;

`ifdef SCAN_CHECKSUM_EN
  logic [31:0] checksum, checksum1;
`endif

  logic [31:0] regs [32];

  assign rf_rdata  = (rf_raddr == 5'd0) ? 32'h0 : regs[rf_raddr];
  assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'h0 : regs[rf_raddr1];

  always #5 clk = ~clk;

  regfile_scan_reader u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .dout_addr  (dout_addr),
    .dout_last  (dout_last),
    .busy       (busy),
    .done       (done)
`ifdef SCAN_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  regfile_scan_reader #(
    .FIRST_REG (5),
    .LAST_REG  (5)
  ) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .abort      (abort1),
    .rf_raddr   (rf_raddr1),
    .rf_rdata   (rf_rdata1),
    .dout_valid (dout_valid1),
    .dout_ready (dout_ready1),
    .dout_data  (dout_data1),
    .dout_addr  (dout_addr1),
    .dout_last  (dout_last1),
    .busy       (busy1),
    .done       (done1)
`ifdef SCAN_CHECKSUM_EN
    ,
    .checksum   (checksum1)
`endif
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
  } exp_t;

  // stall_at/restart_at/abort_at = -1 disables; exp_done_cyc = -1 means no done pulse
  typedef struct {
    int stall_at;
    int stall_len;
    int restart_at;
    int abort_at;
    int exp_words;
    int exp_done_cyc;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int i);
    return (i == 0) ? 32'h0 : regs[i];
  endfunction

  task automatic run_vec(input vec_t v);
    int          last_i, first_valid, done_cyc, words, stall_left;
    bit          ended, stalled_prev;
    logic [4:0]  held_addr;
    logic [31:0] held_data, exp_csum;
    exp_t        e;
    last_i      = (v.abort_at >= 0) ? v.abort_at - 1 : 31;
    exp_csum    = 32'h0;
    for (int i = 0; i <= last_i; i++) begin
      e.addr = 5'(i);
      e.data = exp_data(i);
      e.last = (i == 31);
      sb.push_back(e);
      exp_csum ^= e.data;
    end
    first_valid  = -1;
    done_cyc     = -1;
    words        = 0;
    stall_left   = v.stall_len;
    ended        = 0;
    stalled_prev = 0;
    held_addr    = '0;
    held_data    = '0;
    @(negedge clk);
    start      = 1'b1;
    dout_ready = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      start      = 1'b0;
      abort      = 1'b0;
      dout_ready = 1'b1;
      if (c == 0) begin
        chk("busy_after_start", busy, 1'b1);
        chk("valid_after_start", dout_valid, 1'b0);
      end
      if (dout_valid && first_valid < 0) first_valid = c;
      if (done) begin
        if (done_cyc < 0) done_cyc = c;
        else chk("single_done", 1'b1, 1'b0);
`ifdef SCAN_CHECKSUM_EN
        chk("checksum_at_done", checksum, exp_csum);
`endif
      end
      if (!busy && c > 0) begin
        ended = 1;
        chk("valid_when_idle", dout_valid, 1'b0);
        break;
      end
      if (dout_valid) begin
        if (stalled_prev) begin
          chk("stall_addr_stable", dout_addr, held_addr);
          chk("stall_data_stable", dout_data, held_data);
        end
        if (int'(dout_addr) == v.restart_at) start = 1'b1;
        if (int'(dout_addr) == v.abort_at) begin
          abort = 1'b1;
        end else if (int'(dout_addr) == v.stall_at && stall_left > 0) begin
          dout_ready   = 1'b0;
          stall_left--;
          held_addr    = dout_addr;
          held_data    = dout_data;
          stalled_prev = 1;
        end else begin
          stalled_prev = 0;
          words++;
          if (sb.size() == 0) begin
            chk("unexpected_word", dout_addr, 5'h1f);
            chk("unexpected_word_any", 1'b1, 1'b0);
          end else begin
            e = sb.pop_front();
            chk("word_addr", dout_addr, e.addr);
            chk("word_data", dout_data, e.data);
            chk("word_last", dout_last, e.last);
          end
        end
      end
    end
    if (!ended) chk("scan_timeout", 1'b1, 1'b0);
    chk("word_count", words, v.exp_words);
    chk("done_cycle", done_cyc, v.exp_done_cyc);
    chk("first_valid_cycle", first_valid, 1);
    chk("scoreboard_empty", sb.size(), 0);
    sb.delete();
    start      = 1'b0;
    abort      = 1'b0;
    dout_ready = 1'b1;
  endtask

  vec_t vecs[5];

  initial begin
    bit found;
    vecs[0] = '{stall_at: -1, stall_len: 0, restart_at: -1, abort_at: -1,
                exp_words: 32, exp_done_cyc: 64};
    vecs[1] = '{stall_at: 3, stall_len: 5, restart_at: -1, abort_at: -1,
                exp_words: 32, exp_done_cyc: 69};
    vecs[2] = '{stall_at: -1, stall_len: 0, restart_at: 10, abort_at: -1,
                exp_words: 32, exp_done_cyc: 64};
    vecs[3] = '{stall_at: -1, stall_len: 0, restart_at: -1, abort_at: 7,
                exp_words: 7, exp_done_cyc: -1};
    vecs[4] = '{stall_at: -1, stall_len: 0, restart_at: -1, abort_at: -1,
                exp_words: 32, exp_done_cyc: 64};

    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;

    // Reset state
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_raddr", rf_raddr, 5'd0);
    chk("rst_data", dout_data, 32'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy1", busy1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // Asynchronous reset in the middle of a READ cycle
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dout_valid && dout_addr == 5'd1) begin
        found = 1;
        break;
      end
    end
    chk("reach_word1", found, 1'b1);
    @(posedge clk);
    #2;
    chk("pre_rst_raddr", rf_raddr, 5'd2);
    rst = 1'b0;
    #1;
    chk("async_rst_raddr", rf_raddr, 5'd0);
    chk("async_rst_valid", dout_valid, 1'b0);
    chk("async_rst_data", dout_data, 32'h0);
    chk("async_rst_addr", dout_addr, 5'd0);
    chk("async_rst_last", dout_last, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_after_rst", busy, 1'b0);
    end

    // Single-word scan with FIRST_REG == LAST_REG == 5
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    chk("single_c0_valid", dout_valid1, 1'b0);
    @(negedge clk);
    chk("single_valid", dout_valid1, 1'b1);
    chk("single_addr", dout_addr1, 5'd5);
    chk("single_last", dout_last1, 1'b1);
    chk("single_data", dout_data1, exp_data(5));
    @(negedge clk);
    chk("single_done", done1, 1'b1);
    chk("single_valid_off", dout_valid1, 1'b0);
    @(negedge clk);
    chk("single_idle", busy1, 1'b0);
    chk("single_done_pulse", done1, 1'b0);

`ifdef SCAN_CHECKSUM_EN
    for (int i = 0; i < 32; i++) regs[i] = i;
    run_vec(vecs[0]);
    chk("checksum_regs_i", checksum, 32'h0);
    regs[31] = 32'hFFFF_FFFF;
    run_vec(vecs[0]);
    chk("checksum_r31_ones", checksum, 32'hFFFF_FFE0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
